// File: rtl/turn_pkg.sv
// Shared types for the two-player turn scheduler: FSM state encoding and player identifiers.
package turn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN   = 2'd1,
        SWITCH = 2'd2,
        OVER   = 2'd3
    } turn_state_t;

    typedef logic player_t;

    localparam player_t P1 = 1'b0;
    localparam player_t P2 = 1'b1;

endpackage

// File: rtl/turn_scheduler_sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled and raises tick on the wrapping cycle.
module sec_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    // tick is high on the last count so the consumer acts on the same edge the counter wraps
    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencer for the two-player game: alternates players on accepted moves or turn expiry.
// Pulse semantics: start/move_valid are 1-cycle requests with no backpressure; move_ack/timeout answer them one cycle later.
module turn_scheduler
    import turn_pkg::*;
#(
    parameter int   CLK_HZ       = 50_000_000,
    parameter int   TURN_SECONDS = 15,
    parameter logic FIRST_PLAYER = 1'b0,
    parameter int   CNT_W        = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              move_valid,
    input  logic                              game_over,
    output logic                              game_active,
    output logic                              current_player,
    output logic [$clog2(TURN_SECONDS+1)-1:0] time_left,
    output logic                              move_ack,
    output logic                              timeout,
    output logic [CNT_W-1:0]                  move_count,
    output logic [1:0]                        dbg_state
);

    localparam int              TL_W    = $clog2(TURN_SECONDS + 1);
    localparam logic [TL_W-1:0] TL_FULL = TL_W'(TURN_SECONDS);

    turn_state_t state, state_n;
    logic        tick;

    // Prescaler is held at zero outside TURN, so every entry into TURN starts a fresh second
    sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state != TURN),
        .en    (state == TURN),
        .tick  (tick)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, OVER: if (start) state_n = TURN;
            TURN: begin
                if (game_over)                              state_n = OVER;
                else if (move_valid)                        state_n = SWITCH;
                else if (tick && time_left == TL_W'(1))     state_n = SWITCH;
            end
            SWITCH:  state_n = game_over ? OVER : TURN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            game_active    <= 1'b0;
            current_player <= FIRST_PLAYER;
            time_left      <= '0;
            move_ack       <= 1'b0;
            timeout        <= 1'b0;
            move_count     <= '0;
        end else begin
            state       <= state_n;
            game_active <= (state_n == TURN) || (state_n == SWITCH);
            move_ack    <= 1'b0;
            timeout     <= 1'b0;
            unique case (state)
                IDLE, OVER: begin
                    if (start) begin
                        current_player <= FIRST_PLAYER;
                        time_left      <= TL_FULL;
                        move_count     <= '0;
                    end
                end
                TURN: begin
                    // game_over outranks both a move and an expiring tick
                    if (!game_over) begin
                        if (move_valid) begin
                            move_ack <= 1'b1;
                            if (move_count != '1) move_count <= move_count + CNT_W'(1);
                        end else if (tick) begin
                            if (time_left == TL_W'(1)) begin
                                time_left <= '0;
                                timeout   <= 1'b1;
                            end else begin
                                time_left <= time_left - TL_W'(1);
                            end
                        end
                    end
                end
                SWITCH: begin
                    if (!game_over) begin
                        current_player <= (current_player == P1) ? P2 : P1;
                        time_left      <= TL_FULL;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler: directed scenarios plus randomized play against a cycle-count reference model.
module tb_turn_scheduler;
    import turn_pkg::*;

    localparam int HZ = 4;
    localparam int TS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0, start = 1'b0, move_valid = 1'b0, game_over = 1'b0;
    logic       game_active, current_player, move_ack, timeout;
    logic [1:0] time_left, dbg_state;
    logic [7:0] move_count;
    logic       s_game_active, s_current_player, s_move_ack, s_timeout;
    logic [1:0] s_time_left, s_dbg_state, s_move_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: turn progress tracked as elapsed cycles, seconds derived by division
    bit   m_playing, m_switch, m_over;
    logic m_player, m_ack, m_to;
    int   m_elapsed, m_moves, m_tl;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    turn_scheduler #(.CLK_HZ(HZ), .TURN_SECONDS(TS), .FIRST_PLAYER(1'b0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .move_valid(move_valid), .game_over(game_over),
        .game_active(game_active), .current_player(current_player), .time_left(time_left),
        .move_ack(move_ack), .timeout(timeout), .move_count(move_count), .dbg_state(dbg_state)
    );

    turn_scheduler #(.CLK_HZ(HZ), .TURN_SECONDS(TS), .FIRST_PLAYER(1'b0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .move_valid(move_valid), .game_over(game_over),
        .game_active(s_game_active), .current_player(s_current_player), .time_left(s_time_left),
        .move_ack(s_move_ack), .timeout(s_timeout), .move_count(s_move_count), .dbg_state(s_dbg_state)
    );

    function automatic int sat(input int v, input int cap);
        return (v > cap) ? cap : v;
    endfunction

    task automatic model_step(input logic s, input logic mv, input logic go, input logic r);
        m_ack = 1'b0;
        m_to  = 1'b0;
        if (r) begin
            m_playing = 0; m_switch = 0; m_over = 0; m_player = 1'b0; m_tl = 0; m_moves = 0;
            exp_q.delete();
        end else if (m_switch) begin
            m_switch = 0;
            if (go) m_over = 1;
            else begin
                m_playing = 1; m_player = ~m_player; m_tl = TS; m_elapsed = 0;
            end
        end else if (m_playing) begin
            if (go) begin
                m_playing = 0; m_over = 1;
            end else if (mv) begin
                m_ack = 1'b1; m_moves++; m_playing = 0; m_switch = 1;
                exp_q.push_back(8'(sat(m_moves, 255)));
            end else begin
                m_elapsed++;
                if (m_elapsed == TS * HZ) begin
                    m_to = 1'b1; m_tl = 0; m_playing = 0; m_switch = 1;
                end else begin
                    m_tl = TS - m_elapsed / HZ;
                end
            end
        end else if (s) begin
            m_playing = 1; m_over = 0; m_player = 1'b0; m_elapsed = 0; m_tl = TS; m_moves = 0;
        end
    endtask

    // drive one clock of inputs to both DUTs and the model; outputs are stable 1 time unit after the edge
    task automatic drive_cycle(input logic s, input logic mv, input logic go, input logic r);
        start = s; move_valid = mv; game_over = go; rst = r;
        @(posedge clk);
        model_step(s, mv, go, r);
        #1;
        start = 1'b0; move_valid = 1'b0; game_over = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_cycle(0, 0, 0, 1);
        drive_cycle(0, 0, 0, 1);
        n_cmp++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", dbg_state, IDLE); end
        n_cmp++; if (game_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", game_active); end
        n_cmp++; if (current_player !== 1'b0) begin n_fail++; $display("FAIL reset_player got %b want 0", current_player); end
        n_cmp++; if (time_left !== 2'd0) begin n_fail++; $display("FAIL reset_time_left got %0d want 0", time_left); end
        n_cmp++; if (move_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", move_count); end
        n_cmp++; if (move_ack !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got ack=%b to=%b want 0 0", move_ack, timeout); end
    endtask

    task automatic test_move();
        drive_cycle(0, 0, 0, 1);
        drive_cycle(1, 0, 0, 0);
        n_cmp++; if (game_active !== 1'b1 || time_left !== 2'd3) begin n_fail++; $display("FAIL start_entry got active=%b tl=%0d want 1 3", game_active, time_left); end
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 1, 0, 0);
        n_cmp++; if (move_ack !== 1'b1) begin n_fail++; $display("FAIL move_ack got %b want 1", move_ack); end
        n_cmp++; if (dbg_state !== SWITCH) begin n_fail++; $display("FAIL move_switch got %0d want %0d", dbg_state, SWITCH); end
        n_cmp++; if (move_count !== 8'd1) begin n_fail++; $display("FAIL move_count got %0d want 1", move_count); end
        drive_cycle(0, 0, 0, 0);
        n_cmp++; if (current_player !== 1'b1 || time_left !== 2'd3) begin n_fail++; $display("FAIL move_toggle got p=%b tl=%0d want 1 3", current_player, time_left); end
        n_cmp++; if (move_ack !== 1'b0 || dbg_state !== TURN) begin n_fail++; $display("FAIL move_after got ack=%b st=%0d want 0 %0d", move_ack, dbg_state, TURN); end
    endtask

    task automatic test_timeout();
        drive_cycle(0, 0, 0, 1);
        drive_cycle(1, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            drive_cycle(0, 0, 0, 0);
            n_cmp++; if (time_left !== 2'(m_tl)) begin n_fail++; $display("FAIL timeout_tl cyc=%0d got %0d want %0d", i, time_left, m_tl); end
            n_cmp++; if (timeout !== (i == 12)) begin n_fail++; $display("FAIL timeout_pulse cyc=%0d got %b want %b", i, timeout, (i == 12)); end
        end
        n_cmp++; if (time_left !== 2'd0 || move_ack !== 1'b0) begin n_fail++; $display("FAIL timeout_end got tl=%0d ack=%b want 0 0", time_left, move_ack); end
        drive_cycle(0, 0, 0, 0);
        n_cmp++; if (current_player !== 1'b1 || time_left !== 2'd3) begin n_fail++; $display("FAIL timeout_toggle got p=%b tl=%0d want 1 3", current_player, time_left); end
    endtask

    task automatic test_move_on_expiry();
        drive_cycle(0, 0, 0, 1);
        drive_cycle(1, 0, 0, 0);
        repeat (11) drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 1, 0, 0);
        n_cmp++; if (move_ack !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL expiry_move got ack=%b to=%b want 1 0", move_ack, timeout); end
        n_cmp++; if (move_count !== 8'd1) begin n_fail++; $display("FAIL expiry_count got %0d want 1", move_count); end
    endtask

    task automatic test_game_over();
        drive_cycle(0, 0, 0, 1);
        drive_cycle(1, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 1, 1, 0);
        n_cmp++; if (dbg_state !== OVER || game_active !== 1'b0) begin n_fail++; $display("FAIL over_entry got st=%0d active=%b want %0d 0", dbg_state, game_active, OVER); end
        n_cmp++; if (move_ack !== 1'b0 || current_player !== 1'b0 || move_count !== 8'd0) begin n_fail++; $display("FAIL over_nomove got ack=%b p=%b cnt=%0d want 0 0 0", move_ack, current_player, move_count); end
        drive_cycle(0, 1, 0, 0);
        n_cmp++; if (move_ack !== 1'b0) begin n_fail++; $display("FAIL over_move_ignored got %b want 0", move_ack); end
        drive_cycle(1, 0, 0, 0);
        drive_cycle(0, 1, 0, 0);
        drive_cycle(0, 0, 1, 0);
        n_cmp++; if (dbg_state !== OVER || current_player !== 1'b0 || move_count !== 8'd1) begin n_fail++; $display("FAIL switch_over got st=%0d p=%b cnt=%0d want %0d 0 1", dbg_state, current_player, move_count, OVER); end
    endtask

    task automatic test_mid_reset();
        drive_cycle(0, 0, 0, 1);
        drive_cycle(1, 0, 0, 0);
        drive_cycle(0, 1, 0, 0);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 1);
        n_cmp++; if (dbg_state !== IDLE || game_active !== 1'b0) begin n_fail++; $display("FAIL midrst_state got st=%0d active=%b want %0d 0", dbg_state, game_active, IDLE); end
        n_cmp++; if (current_player !== 1'b0 || time_left !== 2'd0 || move_count !== 8'd0) begin n_fail++; $display("FAIL midrst_vals got p=%b tl=%0d cnt=%0d want 0 0 0", current_player, time_left, move_count); end
    endtask

    task automatic test_saturation();
        drive_cycle(0, 0, 0, 1);
        drive_cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 1, 0, 0);
            n_cmp++; if (s_move_ack !== 1'b1) begin n_fail++; $display("FAIL sat_ack move=%0d got %b want 1", i, s_move_ack); end
            drive_cycle(0, 1, 0, 0);
            n_cmp++; if (s_move_ack !== 1'b0) begin n_fail++; $display("FAIL sat_switch_ignored move=%0d got %b want 0", i, s_move_ack); end
        end
        n_cmp++; if (s_move_count !== 2'd3) begin n_fail++; $display("FAIL sat_count got %0d want 3", s_move_count); end
        n_cmp++; if (move_count !== 8'd5) begin n_fail++; $display("FAIL wide_count got %0d want 5", move_count); end
    endtask

    task automatic test_random();
        int   mv_div;
        logic s, mv, go, r;
        logic [7:0] exp_cnt;
        drive_cycle(0, 0, 0, 1);
        exp_q.delete();
        mv_div = 3;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) mv_div = ($urandom_range(0, 1) == 0) ? 3 : 25;
            s  = ($urandom_range(0, 7) == 0);
            mv = ($urandom_range(0, mv_div - 1) == 0);
            go = ($urandom_range(0, 59) == 0);
            r  = ($urandom_range(0, 499) == 0);
            drive_cycle(s, mv, go, r);
            n_cmp++; if (game_active !== (m_playing || m_switch)) begin n_fail++; $display("FAIL rnd_active cyc=%0d got %b want %b", c, game_active, (m_playing || m_switch)); end
            n_cmp++; if (current_player !== m_player) begin n_fail++; $display("FAIL rnd_player cyc=%0d got %b want %b", c, current_player, m_player); end
            n_cmp++; if (time_left !== 2'(m_tl)) begin n_fail++; $display("FAIL rnd_time_left cyc=%0d got %0d want %0d", c, time_left, m_tl); end
            n_cmp++; if (move_ack !== m_ack || timeout !== m_to) begin n_fail++; $display("FAIL rnd_pulses cyc=%0d got ack=%b to=%b want %b %b", c, move_ack, timeout, m_ack, m_to); end
            n_cmp++; if (s_move_count !== 2'(sat(m_moves, 3))) begin n_fail++; $display("FAIL rnd_sat_count cyc=%0d got %0d want %0d", c, s_move_count, sat(m_moves, 3)); end
            if (move_ack === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_sb_unexpected_ack cyc=%0d got count %0d want no ack", c, move_count);
                end else begin
                    exp_cnt = exp_q.pop_front();
                    if (move_count !== exp_cnt) begin n_fail++; $display("FAIL rnd_sb_count cyc=%0d got %0d want %0d", c, move_count, exp_cnt); end
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_sb_leftover got %0d pending want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_move();
        test_timeout();
        test_move_on_expiry();
        test_game_over();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
